video_timing_scheduler: RTL and testbench
=========================================

VIDEO_TIMING_SCHEDULER -- requirements
Module: video_timing_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch pixels
- H_SYNC, 96, horizontal sync pixels
- H_BP, 48, horizontal back porch pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 0, hsync active level
- VSYNC_POL, 0, vsync active level
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, pixel clock; the only clock
- reset, in, 1, asynchronous, active-high reset
- enable, in, 1, advance timing when high
- hCount, out, 12, pixel index of the current output cycle
- vCount, out, 12, line index of the current output cycle
- hsync, out, 1, horizontal sync at the configured polarity
- vsync, out, 1, vertical sync at the configured polarity
- de, out, 1, active video
- period, out, 2, TMDS period: 0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 VIDEO
- ctl, out, 4, CTL3..CTL0 values sent to the TMDS encoders during control periods
- lineStart, out, 1, one-cycle pulse when hCount is 0
- frameStart, out, 1, one-cycle pulse when hCount and vCount are both 0

Function
REQ-003 Totals SHALL be H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP and V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
REQ-004 The design SHALL require H_FP + H_SYNC + H_BP >= 10, and H_TOTAL and V_TOTAL SHALL each be at most 4096.
REQ-005 Internal counters h and v SHALL advance only when enable=1.
- h SHALL increment by 1 per cycle and wrap from H_TOTAL-1 to 0.
- v SHALL increment when h wraps and wrap from V_TOTAL-1 to 0.
REQ-006 Every output SHALL be registered and SHALL be decoded from the h and v values of the preceding cycle, giving a latency of 1.
- hCount and vCount SHALL be delayed by the same cycle, so all outputs stay mutually aligned.
REQ-007 hsync SHALL equal HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and its inverse otherwise.
REQ-008 vsync SHALL equal VSYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, and its inverse otherwise; vsync changes only at h=0.
REQ-009 de SHALL be 1 exactly when h < H_ACTIVE and v < V_ACTIVE, and period SHALL then be VIDEO.
REQ-010 A "pre-active line" is a line with v = V_TOTAL-1 or v < V_ACTIVE-1.
- On a pre-active line, period SHALL be PREAMBLE for H_TOTAL-10 <= h <= H_TOTAL-3.
- On a pre-active line, period SHALL be GUARD for h >= H_TOTAL-2.
- Everywhere else outside VIDEO, period SHALL be CONTROL.
REQ-011 ctl SHALL be 4'b0001 during PREAMBLE and 4'b0000 in every other period.
REQ-012 The period sequence on a pre-active line SHALL be CONTROL, then 8 PREAMBLE, then 2 GUARD, then VIDEO on the next cycle; no other ordering is legal.
REQ-013 While enable=0:
- h and v SHALL hold.
- The output registers SHALL force period=CONTROL, ctl=0, de=0, and lineStart=frameStart=0.
- hsync, vsync, hCount and vCount SHALL keep their last values.
REQ-014 When enable returns to 1, timing SHALL resume from the held h and v with no skipped or repeated position.
REQ-015 lineStart SHALL pulse for exactly one cycle per line and frameStart for exactly one cycle per frame.

Reset
REQ-016 Asserting reset SHALL, asynchronously:
- clear h, v, hCount and vCount to 0;
- set hsync=~HSYNC_POL and vsync=~VSYNC_POL;
- set de=0, period=CONTROL, ctl=0, lineStart=0 and frameStart=0.
REQ-017 Reset asserted mid-line or mid-preamble SHALL abandon the sequence immediately, with no residual GUARD or VIDEO.
REQ-018 On the first clock edge after reset deasserts with enable=1, outputs SHALL show position (0,0): de=1, period=VIDEO, lineStart=1, frameStart=1.

Verification (default parameters: H_TOTAL=800, V_TOTAL=525)
REQ-019 Release reset with enable=1 -> first output cycle shows (0,0), VIDEO, frameStart=1; the next frameStart arrives exactly 420000 cycles later.
REQ-020 Check line timing -> hsync=0 for hCount 656..751 (96 cycles) per 800-cycle line; de=1 for hCount 0..639 on lines 0..479 only.
REQ-021 Check frame timing -> vsync=0 on lines 490..491 only (1600 cycles), with edges at hCount=0.
REQ-022 Check the period schedule:
- line 524: hCount 790..797 PREAMBLE with ctl=0001; hCount 798..799 GUARD; then (0,0) VIDEO;
- line 478: same schedule as line 524;
- line 479 at hCount 790: CONTROL with ctl=0000.
REQ-023 Drop enable for 50 cycles at (300,100) -> outputs show CONTROL, de=0, frozen counts; after enable rises, de=1 resumes at hCount 300 on line 100.
REQ-024 Assert reset for 1 cycle at line 524, hCount 795 (mid-preamble) -> outputs immediately show reset values; no GUARD is seen; after release, timing restarts at (0,0).

Source files
------------

// File: rtl/video_timing_scheduler.sv
// Raster timing generator: h/v position counters decoded into sync, DE and the
// TMDS control/preamble/guard/video period schedule, all outputs one cycle behind h/v.
module video_timing_scheduler #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        HSYNC_POL = 1'b0,
   parameter logic        VSYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [11:0] hCount,
   output logic [11:0] vCount,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [1:0]  period,
   output logic [3:0]  ctl,
   output logic        lineStart,
   output logic        frameStart
);
   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END    = HS_START + H_SYNC;
   localparam int unsigned VS_START  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END    = VS_START + V_SYNC;
   localparam int unsigned PRE_START = H_TOTAL - 10;
   localparam int unsigned GRD_START = H_TOTAL - 2;

   localparam logic [1:0] PER_CONTROL  = 2'd0;
   localparam logic [1:0] PER_PREAMBLE = 2'd1;
   localparam logic [1:0] PER_GUARD    = 2'd2;
   localparam logic [1:0] PER_VIDEO    = 2'd3;

   logic [11:0] r_h;
   logic [11:0] r_v;
   logic [12:0] w_h;
   logic [12:0] w_v;
   logic        w_h_last;
   logic        w_v_last;
   logic        w_pre_line;
   logic        w_hsync;
   logic        w_vsync;
   logic        w_de;
   logic [1:0]  w_period;
   logic [3:0]  w_ctl;

   logic [11:0] r_hcount;
   logic [11:0] r_vcount;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_de;
   logic [1:0]  r_period;
   logic [3:0]  r_ctl;
   logic        r_line_start;
   logic        r_frame_start;

   // 13-bit views so comparisons against totals of up to 4096 cannot truncate
   assign w_h      = {1'b0, r_h};
   assign w_v      = {1'b0, r_v};
   assign w_h_last = (r_h == 12'(H_TOTAL - 1));
   assign w_v_last = (r_v == 12'(V_TOTAL - 1));

   // Position counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (enable) begin
         if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 12'd0 : r_v + 12'd1;
         end else begin
            r_h <= r_h + 12'd1;
         end
      end
   end

   // Decode of the current position; a pre-active line is one followed by an active line
   always_comb begin
      w_hsync    = ~HSYNC_POL;
      w_vsync    = ~VSYNC_POL;
      w_de       = 1'b0;
      w_period   = PER_CONTROL;
      w_ctl      = 4'b0000;
      w_pre_line = w_v_last || (w_v < 13'(V_ACTIVE - 1));

      if ((w_h >= 13'(HS_START)) && (w_h < 13'(HS_END)))
         w_hsync = HSYNC_POL;
      if ((w_v >= 13'(VS_START)) && (w_v < 13'(VS_END)))
         w_vsync = VSYNC_POL;

      if ((w_h < 13'(H_ACTIVE)) && (w_v < 13'(V_ACTIVE))) begin
         w_de     = 1'b1;
         w_period = PER_VIDEO;
      end else if (w_pre_line && (w_h >= 13'(GRD_START))) begin
         w_period = PER_GUARD;
      end else if (w_pre_line && (w_h >= 13'(PRE_START))) begin
         w_period = PER_PREAMBLE;
      end

      if (w_period == PER_PREAMBLE)
         w_ctl = 4'b0001;
   end

   // Output registers; while stalled, sync and counts hold but the link idles in CONTROL
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_period      <= PER_CONTROL;
         r_ctl         <= 4'b0000;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (enable) begin
         r_hcount      <= r_h;
         r_vcount      <= r_v;
         r_hsync       <= w_hsync;
         r_vsync       <= w_vsync;
         r_de          <= w_de;
         r_period      <= w_period;
         r_ctl         <= w_ctl;
         r_line_start  <= (r_h == 12'd0);
         r_frame_start <= (r_h == 12'd0) && (r_v == 12'd0);
      end else begin
         r_de          <= 1'b0;
         r_period      <= PER_CONTROL;
         r_ctl         <= 4'b0000;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign hCount     = r_hcount;
   assign vCount     = r_vcount;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign de         = r_de;
   assign period     = r_period;
   assign ctl        = r_ctl;
   assign lineStart  = r_line_start;
   assign frameStart = r_frame_start;

endmodule

// File: tb/tb_video_timing_scheduler.sv
// Bench for video_timing_scheduler: a small raster checked every cycle against a
// position-based model, plus literal checks of frame statistics and directed corner cases.
module tb_video_timing_scheduler;
   localparam int HA = 16, HFP = 4, HSW = 5, HBP = 3;
   localparam int VA = 6, VFP = 2, VSW = 2, VBP = 3;
   localparam int HT = HA + HFP + HSW + HBP;   // 28
   localparam int VT = VA + VFP + VSW + VBP;   // 13
   localparam int FRAME = HT * VT;             // 364
   localparam logic HPOL = 1'b0;
   localparam logic VPOL = 1'b1;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [11:0] hCount, vCount;
   logic        hsync, vsync, de, lineStart, frameStart;
   logic [1:0]  period;
   logic [3:0]  ctl;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   video_timing_scheduler #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .hCount(hCount), .vCount(vCount), .hsync(hsync), .vsync(vsync),
      .de(de), .period(period), .ctl(ctl),
      .lineStart(lineStart), .frameStart(frameStart)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: mp is the linear raster position the next enabled cycle will show
   function automatic bit m_hs_act(input int p);
      int h = p % HT;
      return (h >= HA + HFP) && (h < HA + HFP + HSW);
   endfunction

   function automatic bit m_vs_act(input int p);
      int v = p / HT;
      return (v >= VA + VFP) && (v < VA + VFP + VSW);
   endfunction

   function automatic logic [1:0] m_period(input int p);
      int h = p % HT;
      int v = p / HT;
      int rem = HT - h;
      if (h < HA && v < VA) return 2'd3;
      if (((v + 1) % VT) < VA) begin
         if (rem <= 2)  return 2'd2;
         if (rem <= 10) return 2'd1;
      end
      return 2'd0;
   endfunction

   int          mp;
   logic [11:0] e_h, e_v;
   logic        e_hs, e_vs, e_de, e_ls, e_fs;
   logic [1:0]  e_per;
   logic [3:0]  e_ctl;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mp <= 0; e_h <= '0; e_v <= '0; e_hs <= ~HPOL; e_vs <= ~VPOL;
         e_de <= 1'b0; e_per <= 2'd0; e_ctl <= 4'd0; e_ls <= 1'b0; e_fs <= 1'b0;
      end else if (enable) begin
         e_h   <= 12'(mp % HT);
         e_v   <= 12'(mp / HT);
         e_hs  <= m_hs_act(mp) ? HPOL : ~HPOL;
         e_vs  <= m_vs_act(mp) ? VPOL : ~VPOL;
         e_de  <= ((mp % HT) < HA) && ((mp / HT) < VA);
         e_per <= m_period(mp);
         e_ctl <= (m_period(mp) == 2'd1) ? 4'd1 : 4'd0;
         e_ls  <= ((mp % HT) == 0);
         e_fs  <= (mp == 0);
         mp    <= (mp + 1) % FRAME;
      end else begin
         e_de <= 1'b0; e_per <= 2'd0; e_ctl <= 4'd0; e_ls <= 1'b0; e_fs <= 1'b0;
      end
   end

   // Per-cycle compare against the model
   always @(posedge clock) begin
      #2;
      if (chk_on) begin
         cmp("hCount", hCount, e_h);
         cmp("vCount", vCount, e_v);
         cmp("hsync", hsync, e_hs);
         cmp("vsync", vsync, e_vs);
         cmp("de", de, e_de);
         cmp("period", period, e_per);
         cmp("ctl", ctl, e_ctl);
         cmp("lineStart", lineStart, e_ls);
         cmp("frameStart", frameStart, e_fs);
      end
   end

   task automatic chk_reset_vals(input string tag);
      cmp({tag, "_hCount"}, hCount, 0);
      cmp({tag, "_vCount"}, vCount, 0);
      cmp({tag, "_hsync"}, hsync, 1);
      cmp({tag, "_vsync"}, vsync, 0);
      cmp({tag, "_de"}, de, 0);
      cmp({tag, "_period"}, period, 0);
      cmp({tag, "_ctl"}, ctl, 0);
      cmp({tag, "_lineStart"}, lineStart, 0);
      cmp({tag, "_frameStart"}, frameStart, 0);
   endtask

   task automatic wait_pos(input int hx, input int vy);
      int n = 0;
      bit hit = 0;
      while (!hit && n < 2 * FRAME) begin
         @(posedge clock); #2;
         n++;
         if (hCount == 12'(hx) && vCount == 12'(vy) && enable) hit = 1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL wait_pos(%0d,%0d): not reached within %0d cycles", hx, vy, n);
      end
   endtask

   initial begin
      int fs_at = -1, n_fs = 0, n_ls = 0, n_hs = 0, hs_min = 9999, hs_max = -1;
      int n_vs = 0, vs_bad_edge = 0, n_de = 0, n_pre = 0, n_grd = 0, ctl_bad = 0;
      logic prev_vs;

      reset = 1'b1; enable = 1'b0;
      repeat (3) @(posedge clock);
      #2 chk_reset_vals("rst");

      @(negedge clock); reset = 1'b0; enable = 1'b1; chk_on = 1;
      @(posedge clock); #2;
      cmp("first_h", hCount, 0);
      cmp("first_v", vCount, 0);
      cmp("first_de", de, 1);
      cmp("first_period", period, 3);
      cmp("first_ls", lineStart, 1);
      cmp("first_fs", frameStart, 1);
      prev_vs = vsync;

      // One full frame of statistics
      for (int c = 1; c <= FRAME; c++) begin
         @(posedge clock); #2;
         if (frameStart) begin n_fs++; fs_at = c; end
         if (lineStart) n_ls++;
         if (hsync == HPOL) begin
            n_hs++;
            if (int'(hCount) < hs_min) hs_min = int'(hCount);
            if (int'(hCount) > hs_max) hs_max = int'(hCount);
         end
         if (vsync !== prev_vs && hCount != 12'd0) vs_bad_edge++;
         prev_vs = vsync;
         if (vsync == VPOL) n_vs++;
         if (de) n_de++;
         if (period == 2'd1) n_pre++;
         if (period == 2'd2) n_grd++;
         if ((period == 2'd1) ? (ctl != 4'd1) : (ctl != 4'd0)) ctl_bad++;
         if (vCount == 12'd12 && hCount == 12'd17) cmp("l12_h17_ctrl", period, 0);
         if (vCount == 12'd12 && hCount == 12'd18) cmp("l12_h18_pre", {ctl, period}, {4'd1, 2'd1});
         if (vCount == 12'd12 && hCount == 12'd25) cmp("l12_h25_pre", period, 1);
         if (vCount == 12'd12 && hCount == 12'd26) cmp("l12_h26_grd", period, 2);
         if (vCount == 12'd4  && hCount == 12'd18) cmp("l4_h18_pre", period, 1);
         if (vCount == 12'd4  && hCount == 12'd27) cmp("l4_h27_grd", period, 2);
         if (vCount == 12'd5  && hCount == 12'd18) cmp("l5_h18_ctrl", {ctl, period}, 0);
      end
      cmp("frame_fs_interval", fs_at, FRAME);
      cmp("frame_fs_count", n_fs, 1);
      cmp("frame_ls_count", n_ls, VT);
      cmp("hsync_cycles", n_hs, HSW * VT);
      cmp("hsync_first_h", hs_min, 20);
      cmp("hsync_last_h", hs_max, 24);
      cmp("vsync_cycles", n_vs, 2 * HT);
      cmp("vsync_edge_off_h0", vs_bad_edge, 0);
      cmp("de_cycles", n_de, HA * VA);
      cmp("preamble_cycles", n_pre, 8 * 6);
      cmp("guard_cycles", n_grd, 2 * 6);
      cmp("ctl_coding", ctl_bad, 0);

      // Random enable stalls and occasional async reset pulses
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 599) == 0) reset = 1'b1;
         enable = ($urandom_range(0, 9) != 0);
      end
      @(negedge clock); reset = 1'b0; enable = 1'b1;

      // Stall at a mid-line active position
      wait_pos(9, 3);
      @(negedge clock); enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #2;
         cmp("stall_h", hCount, 9);
         cmp("stall_v", vCount, 3);
         cmp("stall_de", de, 0);
         cmp("stall_period", period, 0);
      end
      @(negedge clock); enable = 1'b1;
      @(posedge clock); #2;
      cmp("resume_h", hCount, 10);
      cmp("resume_v", vCount, 3);
      cmp("resume_de", de, 1);

      // Reset in the middle of the preamble on the last line
      wait_pos(23, 12);
      cmp("midpre_period", period, 1);
      @(negedge clock); reset = 1'b1;
      #1 chk_reset_vals("midpre_rst");
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #2;
      cmp("restart_h", hCount, 0);
      cmp("restart_v", vCount, 0);
      cmp("restart_period", period, 3);
      cmp("restart_fs", frameStart, 1);
      @(posedge clock); #2;
      cmp("restart_next_h", hCount, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
